// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types and defaults for the instruction/data memory
//               port arbiter (owner encoding, default widths, counter width).
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int ADDR_W_DEF   = 32;
  localparam int DATA_W_DEF   = 32;
  localparam int STARVE_CNT_W = 8;

  // Who owns the RAM read/write currently in flight (response due next cycle).
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_IF    = 2'd1,
    OWN_DM_RD = 2'd2,
    OWN_DM_WR = 2'd3
  } owner_e;

endpackage
`default_nettype wire

// File: rtl/imem_arb_grant.sv
`default_nettype none
// ============================================================================
// Module      : imem_arb_grant
// Description : Combinational IF/DM grant with fixed DM priority plus the
//               saturating starvation counter that forces an IF grant after
//               MAX_WAIT consecutive denied cycles.
//               Optional macro IMEM_ARB_PERF_EN adds the 'forced' output.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               block          - suppress all grants (reset / post-reset cycle)
//               if_valid       - fetch request pending
//               dm_valid       - data request pending
//               if_grant       - fetch wins this cycle
//               dm_grant       - data wins this cycle
//               forced         - (perf build) IF grant caused by starvation
// Revision    : 1.0 - initial release
// ============================================================================
module imem_arb_grant
  import cpu_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic block,
  input  logic if_valid,
  input  logic dm_valid,
  output logic if_grant,
`ifdef IMEM_ARB_PERF_EN
  output logic dm_grant,
  output logic forced
`else
  output logic dm_grant
`endif
);

  localparam logic [STARVE_CNT_W-1:0] MAX_CNT = STARVE_CNT_W'(MAX_WAIT);

  logic [STARVE_CNT_W-1:0] r_starve_cnt;
  logic                    w_force;

  // Starvation override only matters while IF is actually asking.
  assign w_force  = if_valid && (r_starve_cnt == MAX_CNT);
  assign if_grant = !block && if_valid && (!dm_valid || w_force);
  assign dm_grant = !block && dm_valid && !if_grant;

`ifdef IMEM_ARB_PERF_EN
  assign forced = if_grant && w_force;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (!if_valid || if_grant) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != MAX_CNT) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_port_arbiter
// Description : Shares one single-port synchronous RAM (1-cycle read latency)
//               between the fetch stage (IF) and the memory stage (DM).
//               DM has fixed priority; a starvation counter forces an IF grant
//               after MAX_WAIT denied cycles. Responses return one cycle after
//               the grant and are routed by an owner register.
//               Optional macro IMEM_ARB_PERF_EN adds conflict_cnt/force_cnt.
// Ports       : clk, rst                     - clock, sync active-high reset
//               if_req_* / if_rsp_*, if_flush - fetch request/response
//               dm_req_* / dm_rsp_*           - data request/response
//               ram_addr/ram_wen/ram_wdata/ram_rdata - shared RAM port
//               conflict_cnt, force_cnt       - (perf build) event counters
// Revision    : 1.0 - initial release
// ============================================================================
module imem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  input  logic              if_flush,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              dm_req_valid,
  input  logic              dm_req_we,
  input  logic [ADDR_W-1:0] dm_req_addr,
  input  logic [DATA_W-1:0] dm_req_wdata,
  output logic              dm_req_ready,
  output logic              dm_rsp_valid,
  output logic [DATA_W-1:0] dm_rsp_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wen,
  output logic [DATA_W-1:0] ram_wdata,
`ifdef IMEM_ARB_PERF_EN
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [31:0]       conflict_cnt,
  output logic [31:0]       force_cnt
`else
  input  logic [DATA_W-1:0] ram_rdata
`endif
);

  logic              r_rst_d;
  logic              w_block;
  logic              w_if_grant;
  logic              w_dm_grant;
  owner_e            r_owner;
  owner_e            w_owner_nxt;
  logic [ADDR_W-1:0] r_ram_addr;
`ifdef IMEM_ARB_PERF_EN
  logic              w_forced;
`endif

  // No grants while reset is asserted nor in the cycle right after it, so
  // every ready output stays low across both cycles.
  assign w_block = rst || r_rst_d;

  imem_arb_grant #(
    .MAX_WAIT (MAX_WAIT)
  ) u_grant (
    .clk      (clk),
    .rst      (rst),
    .block    (w_block),
    .if_valid (if_req_valid),
    .dm_valid (dm_req_valid),
    .if_grant (w_if_grant),
`ifdef IMEM_ARB_PERF_EN
    .dm_grant (w_dm_grant),
    .forced   (w_forced)
`else
    .dm_grant (w_dm_grant)
`endif
  );

  // A grant is only ever issued to a valid requester, so grant == accept.
  assign if_req_ready = w_if_grant;
  assign dm_req_ready = w_dm_grant;

  // RAM port: idle cycles keep presenting the last granted address.
  assign ram_addr  = w_if_grant ? if_req_addr :
                     w_dm_grant ? dm_req_addr : r_ram_addr;
  assign ram_wen   = w_dm_grant && dm_req_we;
  assign ram_wdata = dm_req_wdata;

  always_comb begin
    w_owner_nxt = OWN_NONE;
    if (w_if_grant) begin
      w_owner_nxt = OWN_IF;
    end else if (w_dm_grant) begin
      w_owner_nxt = dm_req_we ? OWN_DM_WR : OWN_DM_RD;
    end
  end

  always_ff @(posedge clk) begin
    r_rst_d <= rst;
    if (rst) begin
      r_owner    <= OWN_NONE;
      r_ram_addr <= '0;
    end else begin
      r_owner <= w_owner_nxt;
      if (w_if_grant || w_dm_grant) begin
        r_ram_addr <= ram_addr;
      end
    end
  end

  // Responses: an in-flight read is dropped if reset arrives as it returns.
  assign if_rsp_valid = !rst && (r_owner == OWN_IF) && !if_flush;
  assign if_rsp_data  = if_rsp_valid ? ram_rdata : '0;
  assign dm_rsp_valid = !rst && ((r_owner == OWN_DM_RD) || (r_owner == OWN_DM_WR));
  assign dm_rsp_data  = (!rst && (r_owner == OWN_DM_RD)) ? ram_rdata : '0;

`ifdef IMEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
      force_cnt    <= '0;
    end else begin
      if (if_req_valid && dm_req_valid) begin
        conflict_cnt <= conflict_cnt + 32'd1;
      end
      if (w_forced) begin
        force_cnt <= force_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_port_arbiter
// Description : Directed self-checking bench for imem_port_arbiter with a
//               behavioural 1-cycle-latency RAM (word i preloaded A000_0000|i).
//               Define IMEM_ARB_PERF_EN to also check the perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_flush;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        dm_req_valid;
  logic        dm_req_we;
  logic [31:0] dm_req_addr;
  logic [31:0] dm_req_wdata;
  logic        dm_req_ready;
  logic        dm_rsp_valid;
  logic [31:0] dm_rsp_data;
  logic [31:0] ram_addr;
  logic        ram_wen;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
`ifdef IMEM_ARB_PERF_EN
  logic [31:0] conflict_cnt;
  logic [31:0] force_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:255];

  imem_port_arbiter #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .MAX_WAIT (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req_valid (if_req_valid),
    .if_req_addr  (if_req_addr),
    .if_req_ready (if_req_ready),
    .if_flush     (if_flush),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_data  (if_rsp_data),
    .dm_req_valid (dm_req_valid),
    .dm_req_we    (dm_req_we),
    .dm_req_addr  (dm_req_addr),
    .dm_req_wdata (dm_req_wdata),
    .dm_req_ready (dm_req_ready),
    .dm_rsp_valid (dm_rsp_valid),
    .dm_rsp_data  (dm_rsp_data),
    .ram_addr     (ram_addr),
    .ram_wen      (ram_wen),
    .ram_wdata    (ram_wdata),
`ifdef IMEM_ARB_PERF_EN
    .ram_rdata    (ram_rdata),
    .conflict_cnt (conflict_cnt),
    .force_cnt    (force_cnt)
`else
    .ram_rdata    (ram_rdata)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM, synchronous read, 256 words.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | 32'(i);
  end
  always @(posedge clk) begin
    if (ram_wen) mem[8'(ram_addr >> 2)] <= ram_wdata;
    ram_rdata <= mem[8'(ram_addr >> 2)];
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got hang want finish");
    $fatal(1);
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    if_req_valid = 1'b0;
    dm_req_valid = 1'b0;
    dm_req_we    = 1'b0;
    if_flush     = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    if_flush = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 32'h08;
    dm_req_valid = 1'b1; dm_req_we = 1'b1; dm_req_addr = 32'h40; dm_req_wdata = 32'h1111;
    next_cycle(); next_cycle();
    @(negedge clk);
    checks++; if (if_req_ready !== 1'b0) begin errors++; $display("FAIL rst_if_ready: got %0b want 0", if_req_ready); end
    checks++; if (dm_req_ready !== 1'b0) begin errors++; $display("FAIL rst_dm_ready: got %0b want 0", dm_req_ready); end
    checks++; if (ram_wen !== 1'b0) begin errors++; $display("FAIL rst_ram_wen: got %0b want 0", ram_wen); end
    checks++; if ({if_rsp_valid, dm_rsp_valid} !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid: got %b want 00", {if_rsp_valid, dm_rsp_valid}); end
    next_cycle();
    rst = 1'b0;
    dm_req_valid = 1'b0;
    @(negedge clk);
    checks++; if (if_req_ready !== 1'b0) begin errors++; $display("FAIL post_rst_if_ready: got %0b want 0", if_req_ready); end
    checks++; if (ram_addr !== 32'h0) begin errors++; $display("FAIL post_rst_ram_addr: got %h want 0", ram_addr); end
    checks++; if ({if_rsp_valid, dm_rsp_valid} !== 2'b00) begin errors++; $display("FAIL post_rst_rsp_valid: got %b want 00", {if_rsp_valid, dm_rsp_valid}); end
    next_cycle();
    idle();
    next_cycle();
  endtask

  task automatic test_if_stream;
    logic [31:0] addrs [3];
    logic [31:0] words [3];
    addrs = '{32'h08, 32'h0C, 32'h10};
    words = '{32'hA000_0002, 32'hA000_0003, 32'hA000_0004};
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin if_req_valid = 1'b1; if_req_addr = addrs[i]; end
      else if_req_valid = 1'b0;
      @(negedge clk);
      if (i < 3) begin
        checks++; if (if_req_ready !== 1'b1) begin errors++; $display("FAIL if_stream_ready[%0d]: got %0b want 1", i, if_req_ready); end
        checks++; if (ram_addr !== addrs[i]) begin errors++; $display("FAIL if_stream_addr[%0d]: got %h want %h", i, ram_addr, addrs[i]); end
      end else begin
        checks++; if (if_req_ready !== 1'b0) begin errors++; $display("FAIL if_stream_idle_ready: got %0b want 0", if_req_ready); end
      end
      if (i > 0) begin
        checks++; if (if_rsp_valid !== 1'b1 || if_rsp_data !== words[i-1]) begin
          errors++; $display("FAIL if_stream_rsp[%0d]: got v=%0b d=%h want v=1 d=%h", i-1, if_rsp_valid, if_rsp_data, words[i-1]);
        end
      end
      next_cycle();
    end
    @(negedge clk);
    checks++; if (if_rsp_valid !== 1'b0 || if_rsp_data !== 32'h0) begin
      errors++; $display("FAIL if_stream_quiet: got v=%0b d=%h want v=0 d=0", if_rsp_valid, if_rsp_data);
    end
    next_cycle();
  endtask

  task automatic test_dm_wr_rd;
    dm_req_valid = 1'b1; dm_req_we = 1'b1; dm_req_addr = 32'h40; dm_req_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (dm_req_ready !== 1'b1 || ram_wen !== 1'b1) begin errors++; $display("FAIL dm_wr_issue: got rdy=%0b wen=%0b want 1 1", dm_req_ready, ram_wen); end
    checks++; if (ram_addr !== 32'h40 || ram_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL dm_wr_port: got a=%h d=%h want 40 deadbeef", ram_addr, ram_wdata); end
    next_cycle();
    dm_req_we = 1'b0;
    @(negedge clk);
    checks++; if (dm_rsp_valid !== 1'b1 || dm_rsp_data !== 32'h0) begin errors++; $display("FAIL dm_wr_ack: got v=%0b d=%h want v=1 d=0", dm_rsp_valid, dm_rsp_data); end
    checks++; if (dm_req_ready !== 1'b1 || ram_wen !== 1'b0) begin errors++; $display("FAIL dm_rd_issue: got rdy=%0b wen=%0b want 1 0", dm_req_ready, ram_wen); end
    next_cycle();
    dm_req_valid = 1'b0;
    @(negedge clk);
    checks++; if (dm_rsp_valid !== 1'b1 || dm_rsp_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL dm_rd_rsp: got v=%0b d=%h want v=1 d=deadbeef", dm_rsp_valid, dm_rsp_data); end
    next_cycle();
    @(negedge clk);
    checks++; if (dm_rsp_valid !== 1'b0 || dm_rsp_data !== 32'h0) begin errors++; $display("FAIL dm_quiet: got v=%0b d=%h want v=0 d=0", dm_rsp_valid, dm_rsp_data); end
    checks++; if (ram_addr !== 32'h40) begin errors++; $display("FAIL ram_addr_hold: got %h want 40", ram_addr); end
    next_cycle();
  endtask

  task automatic test_contention;
    logic exp_if;
    if_req_valid = 1'b1; if_req_addr = 32'h08;
    dm_req_valid = 1'b1; dm_req_we = 1'b1; dm_req_addr = 32'h80; dm_req_wdata = 32'h1234;
    for (int k = 0; k < 10; k++) begin
      exp_if = (k == 4) || (k == 9);
      @(negedge clk);
      checks++; if (if_req_ready !== exp_if || dm_req_ready !== !exp_if) begin
        errors++; $display("FAIL contention_ready[%0d]: got if=%0b dm=%0b want if=%0b dm=%0b", k, if_req_ready, dm_req_ready, exp_if, !exp_if);
      end
      checks++; if (ram_wen !== !exp_if || ram_addr !== (exp_if ? 32'h08 : 32'h80)) begin
        errors++; $display("FAIL contention_port[%0d]: got wen=%0b a=%h want wen=%0b a=%h", k, ram_wen, ram_addr, !exp_if, exp_if ? 32'h08 : 32'h80);
      end
      next_cycle();
    end
    idle();
`ifdef IMEM_ARB_PERF_EN
    checks++; if (conflict_cnt !== 32'd10) begin errors++; $display("FAIL perf_conflict_cnt: got %0d want 10", conflict_cnt); end
    checks++; if (force_cnt !== 32'd2) begin errors++; $display("FAIL perf_force_cnt: got %0d want 2", force_cnt); end
`endif
    @(negedge clk);
    checks++; if (if_rsp_valid !== 1'b1 || if_rsp_data !== 32'hA000_0002) begin
      errors++; $display("FAIL contention_if_rsp: got v=%0b d=%h want v=1 d=a0000002", if_rsp_valid, if_rsp_data);
    end
    next_cycle();
  endtask

  task automatic test_flush;
    if_req_valid = 1'b1; if_req_addr = 32'h0C;
    @(negedge clk);
    checks++; if (if_req_ready !== 1'b1) begin errors++; $display("FAIL flush_first_ready: got %0b want 1", if_req_ready); end
    next_cycle();
    if_flush = 1'b1; if_req_addr = 32'h10;
    @(negedge clk);
    checks++; if (if_rsp_valid !== 1'b0 || if_rsp_data !== 32'h0) begin errors++; $display("FAIL flush_squash: got v=%0b d=%h want v=0 d=0", if_rsp_valid, if_rsp_data); end
    checks++; if (if_req_ready !== 1'b1 || ram_addr !== 32'h10) begin errors++; $display("FAIL flush_redirect: got rdy=%0b a=%h want 1 10", if_req_ready, ram_addr); end
    next_cycle();
    if_flush = 1'b0; if_req_valid = 1'b0;
    @(negedge clk);
    checks++; if (if_rsp_valid !== 1'b1 || if_rsp_data !== 32'hA000_0004) begin errors++; $display("FAIL flush_redirect_rsp: got v=%0b d=%h want v=1 d=a0000004", if_rsp_valid, if_rsp_data); end
    next_cycle();
  endtask

  task automatic test_reset_midop;
    logic exp_if;
    if_req_valid = 1'b1; if_req_addr = 32'h08;
    dm_req_valid = 1'b1; dm_req_we = 1'b0; dm_req_addr = 32'h40; dm_req_wdata = 32'h5555;
    // Four DM reads win; starvation count climbs to MAX_WAIT.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (dm_req_ready !== 1'b1) begin errors++; $display("FAIL midop_dm_ready[%0d]: got %0b want 1", k, dm_req_ready); end
      next_cycle();
    end
    rst = 1'b1; dm_req_we = 1'b1;
    @(negedge clk);
    checks++; if (dm_rsp_valid !== 1'b0 || dm_rsp_data !== 32'h0) begin errors++; $display("FAIL midop_rsp_dropped: got v=%0b d=%h want v=0 d=0", dm_rsp_valid, dm_rsp_data); end
    checks++; if (ram_wen !== 1'b0 || if_req_ready !== 1'b0 || dm_req_ready !== 1'b0) begin
      errors++; $display("FAIL midop_rst_port: got wen=%0b ifr=%0b dmr=%0b want 0 0 0", ram_wen, if_req_ready, dm_req_ready);
    end
    next_cycle();
    rst = 1'b0; dm_req_we = 1'b0;
    @(negedge clk);
    checks++; if ({if_rsp_valid, dm_rsp_valid, if_req_ready, dm_req_ready} !== 4'b0000) begin
      errors++; $display("FAIL midop_post_rst: got %b want 0000", {if_rsp_valid, dm_rsp_valid, if_req_ready, dm_req_ready});
    end
    checks++; if (ram_addr !== 32'h0) begin errors++; $display("FAIL midop_ram_addr: got %h want 0", ram_addr); end
    next_cycle();
    // Cleared counter: one denied cycle already, so IF wins on the fourth cycle.
    for (int k = 0; k < 4; k++) begin
      exp_if = (k == 3);
      @(negedge clk);
      checks++; if (if_req_ready !== exp_if || dm_req_ready !== !exp_if) begin
        errors++; $display("FAIL midop_starve[%0d]: got if=%0b dm=%0b want if=%0b dm=%0b", k, if_req_ready, dm_req_ready, exp_if, !exp_if);
      end
      next_cycle();
    end
    idle();
    next_cycle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    if_req_addr  = '0;
    dm_req_addr  = '0;
    dm_req_wdata = '0;
    test_reset();
    test_if_stream();
    test_dm_wr_rd();
    test_contention();
    test_flush();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
